// File: rtl/load_align_unit.sv
// Load path: aligned bus reads, byte extraction and sign/zero extension.
// Optional MISALIGN_SPLIT_EN serves word-crossing loads with two reads.
module load_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_ctrl,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
`ifdef MISALIGN_SPLIT_EN
    REQ1,
    WAIT1,
`endif
    RESP
  } state_t;

  // {sign, log2(size)}; codes beyond the native width fold onto the widest load
  function automatic logic [2:0] decode(input logic [2:0] c);
    logic [2:0] r;
    unique case (c)
      3'b000:  r = 3'b100;
      3'b001:  r = 3'b101;
      3'b010:  r = 3'b110;
      3'b011:  r = 3'b000;
      3'b100:  r = 3'b001;
      3'b101:  r = (XLEN == 64) ? 3'b010 : 3'b110;
      default: r = (XLEN == 64) ? 3'b111 : 3'b110;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sz_q, sz_d;
  logic              sgn_q, sgn_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   w0_q, w0_d;
  logic [XLEN-1:0]   w1;

`ifdef MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   w1_q, w1_d;
  logic              split_q, split_d;
  assign w1 = w1_q;
`else
  assign w1 = '0;
`endif

  logic [2:0]        dec_in;
  logic [4:0]        end_in;
  logic              mis_in;
  logic [ADDR_W-1:0] base;

  assign dec_in = decode(req_ctrl);
  assign end_in = 5'(req_addr[OFF_W-1:0]) + (5'd1 << dec_in[1:0]);
  assign mis_in = end_in > 5'(NB);
  assign base   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  logic [2*XLEN-1:0]      cat;
  logic [XLEN-1:0]        raw;
  logic [6:0]             sh;
  logic [XLEN-1:0]        ul;
  logic signed [XLEN-1:0] us;
  logic [XLEN-1:0]        ext;

  // Park the access at the top of the word, then shift back down
  // arithmetically or logically to extend from its top bit.
  always_comb begin
    cat = {w1, w0_q} >> {addr_q[OFF_W-1:0], 3'b000};
    raw = cat[XLEN-1:0];
    sh  = 7'(XLEN) - (7'd8 << sz_q);
    ul  = raw << sh;
    us  = $signed(ul);
    ext = sgn_q ? $unsigned(us >>> sh) : (ul >> sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sz_q    <= '0;
      sgn_q   <= 1'b0;
      tag_q   <= '0;
      fault_q <= 1'b0;
      w0_q    <= '0;
`ifdef MISALIGN_SPLIT_EN
      w1_q    <= '0;
      split_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sz_q    <= sz_d;
      sgn_q   <= sgn_d;
      tag_q   <= tag_d;
      fault_q <= fault_d;
      w0_q    <= w0_d;
`ifdef MISALIGN_SPLIT_EN
      w1_q    <= w1_d;
      split_q <= split_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    sz_d          = sz_q;
    sgn_d         = sgn_q;
    tag_d         = tag_q;
    fault_d       = fault_q;
    w0_d          = w0_q;
`ifdef MISALIGN_SPLIT_EN
    w1_d          = w1_q;
    split_d       = split_q;
`endif
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    resp_tag      = '0;
    resp_fault    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          addr_d  = req_addr;
          sgn_d   = dec_in[2];
          sz_d    = dec_in[1:0];
          tag_d   = req_tag;
          fault_d = 1'b0;
`ifdef MISALIGN_SPLIT_EN
          split_d = mis_in;
          state_d = REQ0;
`else
          if (mis_in) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ0;
          end
`endif
        end
      end
      REQ0: begin
        mem_req_valid = 1'b1;
        mem_addr      = base;
        if (mem_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rsp_valid) begin
          w0_d = mem_rsp_data;
          if (mem_rsp_err) begin
            fault_d = 1'b1;
            state_d = RESP;
          end
`ifdef MISALIGN_SPLIT_EN
          else if (split_q) state_d = REQ1;
`endif
          else state_d = RESP;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      REQ1: begin
        mem_req_valid = 1'b1;
        mem_addr      = base + ADDR_W'(NB);
        if (mem_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rsp_valid) begin
          w1_d    = mem_rsp_data;
          fault_d = mem_rsp_err;
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = fault_q ? '0 : ext;
        resp_tag   = tag_q;
        resp_fault = fault_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
